tmr_scrub_regfile: RTL
======================

# tmr_scrub_regfile

Parametrised triplicated register file with majority-voted reads and a background scrubber that repairs single-copy upsets. It replaces the fixed 14 x 8-bit register arrays used in our triplication test designs with a reusable WIDTH x DEPTH storage block. It sits between control logic and any state that must survive SEUs. A fault-injection port lets benches corrupt one copy directly.

## Interface
- WIDTH, 8, data width in bits
- DEPTH, 14, number of words; minimum 2
- AW, $clog2(DEPTH), address width (derived, not overridden)
- SCRUB_INTERVAL, 16, idle cycles between scrub checks; minimum 1
- ERRCNT_W, 8, correction counter width
- clk  input  1  clock, all logic on the rising edge
- rstn  input  1  reset, asynchronous, active-low
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data, written to all three copies
- rd_addr  input  AW  read address
- rd_data  output  WIDTH  voted read data, registered
- rd_err  output  1  copies disagreed at the read address, registered with rd_data
- inject_en  input  1  fault-injection strobe
- inject_copy  input  2  target copy: 0, 1 or 2; value 3 ignored
- inject_addr  input  AW  injection address
- inject_mask  input  WIDTH  XOR mask applied to the target copy
- scrub_busy  output  1  scrubber in CHECK or FIX
- err_cnt  output  ERRCNT_W  scrub corrections performed, saturating

## Operation
- Storage: three arrays A, B and C of DEPTH x WIDTH. Vote is bitwise majority (A&B | A&C | B&C).
- Write: when wr_en=1 and wr_addr<DEPTH, wr_data goes to A, B and C at wr_addr. Writes with wr_addr>=DEPTH are ignored.
- Read:
  - rd_data is the vote at rd_addr.
  - rd_err=1 when A, B and C are not all equal at rd_addr.
  - If rd_addr>=DEPTH, rd_data=0 and rd_err=0.
- Injection: when inject_en=1, inject_copy<3 and inject_addr<DEPTH, the selected copy word is XORed with inject_mask. Injection is ignored in any cycle where wr_en=1.
- Scrubber FSM, states WAIT, CHECK, FIX; scrub pointer ptr:
  - WAIT: count SCRUB_INTERVAL cycles, then go to CHECK.
  - CHECK: compare the copies at ptr and latch the vote and a mismatch flag. Go to FIX.
  - FIX: if wr_en=1 at any address, hold in FIX (stall). Otherwise:
    - if the mismatch flag is set, write the latched vote to all copies at ptr and increment err_cnt (saturating at all-ones);
    - advance ptr, wrapping from DEPTH-1 to 0;
    - go to WAIT.
  - A wr_en write to ptr while in CHECK or FIX clears the mismatch flag. The correction is dropped and not counted; write data wins.
- Double-copy corruption of the same bit is outside the fault model. The scrubber writes back the corrupt vote silently.

## Timing
- Reset, asynchronous on rstn low:
  - A, B, C all 0; rd_data=0, rd_err=0, err_cnt=0, scrub_busy=0;
  - FSM in WAIT with the interval counter at 0; ptr=0.
- Read latency 1 cycle: rd_addr sampled at edge N is presented at edge N+1.
- Read of an address written in the same cycle returns the old value (read-before-write).
- Write and injection take effect at the edge where they are sampled.
- First CHECK occurs SCRUB_INTERVAL cycles after reset release. Each unstalled scrub step takes SCRUB_INTERVAL+2 cycles.
- A full sweep takes DEPTH*(SCRUB_INTERVAL+2) cycles plus any stall cycles.
- scrub_busy is high exactly during CHECK and FIX cycles, including stall cycles.
- Reset asserted mid-scrub aborts the step. No partial correction is written.

## Configuration
- TMR_SCRUB_EN defined: scrubber FSM, ptr and err_cnt are implemented as above.
- TMR_SCRUB_EN undefined:
  - no scrubber logic; scrub_busy and err_cnt are tied to 0;
  - corrections occur only through normal writes;
  - the read path, rd_err and injection are unchanged, and all ports remain present.

## Test plan
- Write 8'hA5 to address 3, read address 3: rd_data=8'hA5 and rd_err=0 one cycle later.
- Inject mask 8'h0F into copy 1 at address 3, read address 3: rd_data=8'hA5, rd_err=1.
- After that injection, with defaults (SCRUB_INTERVAL=16), idle the bus until ptr reaches 3. Required: err_cnt=1, and a subsequent read of address 3 gives rd_err=0.
- Injection at ptr during CHECK, with wr_en=1 writing 8'h3C to ptr on the FIX cycle:
  - FSM stalls while wr_en is high;
  - the correction is dropped and err_cnt is unchanged;
  - a read returns 8'h3C with rd_err=0.
- Set ERRCNT_W=2 and inject 5 separate single-copy faults: err_cnt saturates at 2'b11. Pulse rstn low mid-FIX: all outputs read 0 and the FSM restarts in WAIT.
- Write to address 14 (out of range) with DEPTH=14: no array change. Read of address 14 gives rd_data=0, rd_err=0. Without TMR_SCRUB_EN, scrub_busy and err_cnt stay 0 for 1000 cycles.

Source files
------------

// File: rtl/tmr_scrub_regfile.sv
// tmr_scrub_regfile: triplicated WIDTH x DEPTH register file with majority-voted reads.
// Background scrubber (FSM, ptr, err_cnt) is built only when TMR_SCRUB_EN is defined.
module tmr_scrub_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 14,
    parameter int SCRUB_INTERVAL = 16,
    parameter int ERRCNT_W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_err,
    input  logic                inject_en,
    input  logic [1:0]          inject_copy,
    input  logic [AW-1:0]       inject_addr,
    input  logic [WIDTH-1:0]    inject_mask,
    output logic                scrub_busy,
    output logic [ERRCNT_W-1:0] err_cnt
);
    localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [WIDTH-1:0] mem_c [DEPTH];
    logic wr_ok, inj_ok, rd_ok;

    function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] a, b, c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign wr_ok  = wr_en && ({1'b0, wr_addr} < LIM);
    assign inj_ok = inject_en && !wr_en && inject_copy != 2'd3 && ({1'b0, inject_addr} < LIM);
    assign rd_ok  = {1'b0, rd_addr} < LIM;

`ifdef TMR_SCRUB_EN
    localparam int CW = $clog2(SCRUB_INTERVAL + 1);
    typedef enum logic [1:0] {WAIT, CHECK, FIX} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [AW-1:0] ptr;
    logic [WIDTH-1:0] vote_q;
    logic flag, step, fix_wr, hit;

    assign step       = state == FIX && !wr_en;
    assign fix_wr     = step && flag;
    assign hit        = wr_ok && wr_addr == ptr;
    assign scrub_busy = state != WAIT;

    always_comb begin
        state_nx = state;
        state_nx = (state == WAIT && cnt == CW'(SCRUB_INTERVAL - 1)) ? CHECK :
                   (state == CHECK) ? FIX :
                   step ? WAIT : state;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= WAIT;
            cnt     <= '0;
            ptr     <= '0;
            vote_q  <= '0;
            flag    <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == WAIT && state_nx == WAIT) ? cnt + 1'b1 : '0;
            if (state == CHECK) begin
                vote_q <= vote(mem_a[ptr], mem_b[ptr], mem_c[ptr]);
                flag   <= !hit && !(mem_a[ptr] == mem_b[ptr] && mem_b[ptr] == mem_c[ptr]);
            end else if (state == FIX && hit) begin
                flag <= 1'b0;
            end
            if (fix_wr)
                err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
            if (step)
                ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end
`else
    assign scrub_busy = 1'b0;
    assign err_cnt    = '0;
`endif

    // Injection is applied last so it lands on top of any scrub write-back at the same word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
                mem_c[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem_a[wr_addr] <= wr_data;
                mem_b[wr_addr] <= wr_data;
                mem_c[wr_addr] <= wr_data;
            end
`ifdef TMR_SCRUB_EN
            else if (fix_wr) begin
                mem_a[ptr] <= vote_q;
                mem_b[ptr] <= vote_q;
                mem_c[ptr] <= vote_q;
            end
`endif
            if (inj_ok && inject_copy == 2'd0)
                mem_a[inject_addr] <= mem_a[inject_addr] ^ inject_mask;
            if (inj_ok && inject_copy == 2'd1)
                mem_b[inject_addr] <= mem_b[inject_addr] ^ inject_mask;
            if (inj_ok && inject_copy == 2'd2)
                mem_c[inject_addr] <= mem_c[inject_addr] ^ inject_mask;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            rd_data <= rd_ok ? vote(mem_a[rd_addr], mem_b[rd_addr], mem_c[rd_addr]) : '0;
            rd_err  <= rd_ok && !(mem_a[rd_addr] == mem_b[rd_addr] && mem_b[rd_addr] == mem_c[rd_addr]);
        end
    end
endmodule
